// File: rtl/dcm_phase_stepper.sv
// DCM DIRECT-mode phase-shift sequencer: walks PSEN/PSINCDEC one tap
// at a time toward a host target, tracking the DCM tap with a PSDONE timeout.
module dcm_phase_stepper #(
    parameter int PHASE_WIDTH    = 10,
    parameter int MAX_PHASE      = 1023,
    parameter int PSDONE_TIMEOUT = 255,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic                   I_clk,
    input  logic                   I_reset,
    input  logic                   I_dcm_locked,
    input  logic                   I_psdone,
    input  logic [PHASE_WIDTH-1:0] I_target,
    input  logic                   I_target_valid,
    output logic                   O_psen,
    output logic                   O_psincdec,
    output logic [PHASE_WIDTH-1:0] O_current,
    output logic                   O_busy,
    output logic                   O_done,
    output logic                   O_timeout,
    output logic [2:0]             O_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        COMPARE   = 3'd2,
        STEP      = 3'd3,
        WAIT_DONE = 3'd4,
        SETTLE    = 3'd5,
        ERROR     = 3'd6
    } state_t;

    localparam int CNT_MAX = (PSDONE_TIMEOUT > SETTLE_CYCLES) ?
                             PSDONE_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PHASE_WIDTH-1:0] MAX_TAP = PHASE_WIDTH'(MAX_PHASE);
    // The PSEN cycle itself counts toward the timeout window.
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(PSDONE_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [PHASE_WIDTH-1:0] target;
    logic [PHASE_WIDTH-1:0] current;
    logic [PHASE_WIDTH-1:0] target_clamped;
    logic                   pending;
    logic                   psincdec;
    logic                   timeout;
    logic [CNT_W-1:0]       cnt;
    logic                   at_target;

    assign at_target      = (current == target);
    assign target_clamped = (I_target > MAX_TAP) ? MAX_TAP : I_target;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state <= WAIT_LOCK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ERROR) begin
            if (I_target_valid) begin
                state_next = COMPARE;
            end
        end else if (!I_dcm_locked) begin
            state_next = WAIT_LOCK;
        end else begin
            case (state)
                IDLE: begin
                    if (I_target_valid || pending) begin
                        state_next = COMPARE;
                    end
                end
                WAIT_LOCK: state_next = COMPARE;
                COMPARE:   state_next = at_target ? IDLE : STEP;
                STEP:      state_next = WAIT_DONE;
                WAIT_DONE: begin
                    if (I_psdone) begin
                        state_next = SETTLE;
                    end else if (cnt == TO_LAST) begin
                        state_next = ERROR;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_next = COMPARE;
                    end
                end
                default: state_next = WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        O_psen  = (state == STEP);
        O_done  = (state == COMPARE) && I_dcm_locked && at_target && pending;
        O_busy  = (state != IDLE) && (state != ERROR);
        O_state = state;
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            target   <= '0;
            pending  <= 1'b0;
            current  <= '0;
            psincdec <= 1'b0;
            timeout  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (I_target_valid) begin
                target  <= target_clamped;
                pending <= 1'b1;
            end else if (O_done) begin
                pending <= 1'b0;
            end

            if (state == ERROR) begin
                if (I_target_valid) begin
                    timeout <= 1'b0;
                end
            end else if (!I_dcm_locked) begin
                // A DCM reset re-zeros the DIRECT-mode phase.
                current <= '0;
            end else begin
                case (state)
                    COMPARE: begin
                        if (!at_target) begin
                            psincdec <= (target > current);
                        end
                    end
                    STEP: cnt <= '0;
                    WAIT_DONE: begin
                        if (I_psdone) begin
                            current <= psincdec ? current + 1'b1
                                                : current - 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (cnt == TO_LAST) begin
                                timeout <= 1'b1;
                            end
                        end
                    end
                    SETTLE:  cnt <= cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign O_psincdec = psincdec;
    assign O_current  = current;
    assign O_timeout  = timeout;

endmodule

// File: doc/dcm_phase_stepper.md
Name: dcm_phase_stepper

Overview:
Sequencer for the DCM's variable phase-shift port (PSEN/PSINCDEC/PSDONE) in DIRECT mode. It accepts a target phase tap from the host, then walks the DCM one tap at a time toward it. Each step waits for PSDONE with a timeout, and the block tracks the DCM's current tap. It runs on the reference clock that drives PSCLK and sits beside the DRP controller in the DCM top level.

Parameters:
PHASE_WIDTH, 10, width of tap count and target
MAX_PHASE, 1023, highest legal tap; larger targets are clamped to it
PSDONE_TIMEOUT, 255, cycles to wait for PSDONE after PSEN before error
SETTLE_CYCLES, 4, idle cycles after PSDONE before the next step (minimum 1)

Ports:
I_clk  in  1  reference clock; also drives DCM PSCLK
I_reset  in  1  synchronous, active-high reset
I_dcm_locked  in  1  DCM LOCKED status
I_psdone  in  1  DCM PSDONE
I_target  in  PHASE_WIDTH  requested tap, unsigned
I_target_valid  in  1  one-cycle strobe; latches I_target
O_psen  out  1  DCM PSEN, single-cycle pulse
O_psincdec  out  1  DCM PSINCDEC: 1 = increment, 0 = decrement
O_current  out  PHASE_WIDTH  tap the DCM is currently at
O_busy  out  1  high outside IDLE and ERROR
O_done  out  1  one-cycle pulse when a request completes
O_timeout  out  1  sticky error flag
O_state  out  3  state encoding, for debug

Behaviour:
- Clock and reset: a single clock, I_clk. I_reset is synchronous and active-high.
- Reset values: state WAIT_LOCK; O_psen, O_psincdec, O_done, O_timeout all 0; O_current 0; target register 0; pending flag 0; counters 0.
- States: IDLE=0, WAIT_LOCK=1, COMPARE=2, STEP=3, WAIT_DONE=4, SETTLE=5, ERROR=6.
- Target capture (every state):
  - I_target_valid latches min(I_target, MAX_PHASE) and sets pending.
  - The latest strobe wins; an in-flight step is never aborted.
  - A strobe in ERROR clears O_timeout and moves to COMPARE on the next cycle.
- Lock loss: I_dcm_locked=0 in any state other than ERROR does the following on the next edge:
  - go to WAIT_LOCK, O_current:=0 (DCM reset re-zeros DIRECT phase), O_psen:=0;
  - target and pending are retained;
  - lock loss overrides a simultaneous PSDONE.
- WAIT_LOCK: when I_dcm_locked=1, go to COMPARE.
- COMPARE:
  - current==target: go to IDLE; if pending, O_done=1 for this cycle and pending:=0.
  - current!=target: go to STEP.
- STEP (exactly one cycle):
  - O_psen=1;
  - O_psincdec=1 if target>current, else 0 (registered, held stable until the next STEP);
  - clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - I_psdone=1: O_current ±1 in the direction of O_psincdec, go to SETTLE.
  - Otherwise the counter increments; on reaching PSDONE_TIMEOUT go to ERROR and set O_timeout=1.
  - PSDONE outside WAIT_DONE is ignored.
- SETTLE: wait SETTLE_CYCLES cycles, then go to COMPARE. The new target is re-evaluated here, so direction may reverse mid-walk.
- IDLE: I_target_valid goes to COMPARE on the next cycle.
- ERROR: O_current is frozen. Exit only by I_target_valid or I_reset; lock changes are ignored.
- O_current never wraps: increments only while below target (≤MAX_PHASE) and decrements only while above target (≥0).
- Minimum cost per tap, counting from STEP: 1 STEP + (PSDONE latency, at least 1) + SETTLE_CYCLES + 1 COMPARE.
- O_done and O_psen are never asserted in the same cycle.

Test Plan:
- Reset with locked=1, target 5 strobed, PSDONE returned 3 cycles after each PSEN -> exactly 5 PSEN pulses, all with psincdec=1; O_current steps 1..5; one O_done; O_busy low afterwards.
- From current=5, target 2 -> 3 PSEN pulses with psincdec=0; O_current=2; O_done once. Re-strobe target 2 -> O_done pulses with no PSEN.
- Target 2000 -> clamped; O_current reaches 1023; no wrap.
- Target 10, then a strobe of target 3 while at current=6 -> direction reverses at the next STEP; final O_current=3; a single O_done.
- PSDONE withheld -> O_timeout=1 exactly 255 cycles after PSEN; state ERROR; later PSDONE is ignored. Strobe target 0 -> O_timeout clears, walk resumes.
- Drop I_dcm_locked in WAIT_DONE at current=4 (target 8) -> WAIT_LOCK, O_current=0. Relock -> walks 0..8 and O_done fires.
